wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Shares one pipelined Wishbone slave port between `NUM_REQUESTERS` Wishbone masters. It grants the bus round-robin for the whole duration of a master's `cyc`. It tracks outstanding (accepted but unacknowledged) strobes so it can throttle issue and route acks correctly. It sits in front of a `wb_interconnect` or a single slave, mirroring the interconnect's flattened per-port signalling on the requester side.

## Interface
Parameters:
- `NUM_REQUESTERS`, 2: number of upstream masters.
- `ADDR_BITS`, 1: address width.
- `BYTES`, 1: data width in bytes.
- `SEL_WIDTH`, 1: select width.
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unacked strobes; must be ≥1.

Ports:
- `clk`  in  1  sole clock.
- `sreset`  in  1  reset; synchronous and active-high.
- `s_addr`  in  NUM_REQUESTERS*ADDR_BITS  per-requester address, flattened, requester i at `[(i+1)*W-1 -: W]`.
- `s_dat_m2s`  in  NUM_REQUESTERS*BYTES*8  write data.
- `s_dat_s2m`  out  NUM_REQUESTERS*BYTES*8  read data.
- `s_we`, `s_stb`, `s_cyc`  in  NUM_REQUESTERS  per-requester controls.
- `s_sel`  in  NUM_REQUESTERS*SEL_WIDTH  byte selects.
- `s_ack`, `s_stall`  out  NUM_REQUESTERS  per-requester responses.
- `m_wb`  wishbone.master  —  shared downstream bus.

## Operation
- Two states: IDLE and GRANT, plus a `grant` index register, a round-robin pointer and an outstanding counter `outst` (width $clog2(MAX_OUTSTANDING+1)).
- IDLE:
  - `m_wb.cyc`, `m_wb.stb` = 0.
  - All `s_stall` = 1, all `s_ack` = 0.
  - When any `s_cyc[i]` is high, select the first requester at or after the pointer (wrapping), register it in `grant`, and go to GRANT.
- GRANT:
  - `m_wb` addr/dat_m2s/we/sel/cyc are the granted requester's.
  - `m_wb.stb` = `s_stb[grant]` && (`outst` < MAX_OUTSTANDING).
  - `s_stall[grant]` = `m_wb.stall` || (`outst` == MAX_OUTSTANDING).
  - `s_ack[grant]` = `m_wb.ack`, and `s_dat_s2m` of the granted slice = `m_wb.dat_s2m`.
  - Non-granted requesters: stall=1, ack=0, dat_s2m=0.
- Counter:
  - +1 on `m_wb.stb && !m_wb.stall`; −1 on `m_wb.ack`.
  - Both in the same cycle: unchanged.
  - Ack at `outst`=0: ignored, counter stays 0.
- Release: when `s_cyc[grant]` = 0 in GRANT, next state is IDLE, `outst` clears to 0, and the pointer becomes `grant`+1 mod NUM_REQUESTERS. Early cyc drop is treated as an abort; late acks are not forwarded.
- Requesters not granted hold `cyc`/`stb`; they are stalled, never dropped.

## Timing
- Reset values:
  - State IDLE, `grant`=0, pointer=0, `outst`=0.
  - `m_wb.cyc`/`stb`=0, all `s_stall`=1, `s_ack`=0, `s_dat_s2m`=0.
- Grant latency: `s_cyc` rises in cycle n (IDLE), and `m_wb.cyc` is high in cycle n+1.
- Datapath in GRANT is purely combinational: zero added latency on stb/stall/ack/data.
- Minimum one IDLE cycle between consecutive grants.
- `sreset` mid-transfer: the next edge forces IDLE, and `m_wb.cyc` is low the following cycle.

## Structure
- Package `wb_arbiter_pkg`: state enum (`IDLE`, `GRANT`).
- Sub-module `rr_select`: combinational round-robin pick (`req`, `ptr` → `valid`, `idx`), reusable by other arbiters.
- Counter and FSM live in `wb_arbiter`.

## Test plan
- **Single requester:** requester 1 issues 3 back-to-back reads, slave acks each one cycle later → `m_wb.cyc` high from cycle after `s_cyc`, `s_ack[1]` ×3, data matches, `s_stall[0]`=1 throughout.
- **Round-robin:** requesters 0 and 2 hold `cyc` continuously with NUM_REQUESTERS=3 → grants alternate 0,2,0,2 with one IDLE cycle between each.
- **Throttle:** MAX_OUTSTANDING=2, slave never acks and stall=0, requester issues 4 stb → exactly 2 accepted on `m_wb`, then `s_stall[grant]`=1 and `m_wb.stb`=0; first ack re-enables one issue.
- **Simultaneous accept and ack:** with `outst`=1, a stb is accepted in the same cycle as an ack → `outst` stays 1; a spurious ack at `outst`=0 keeps it at 0.
- **Abort:** granted requester drops `cyc` with `outst`=2 → IDLE next cycle, `outst`=0, later `m_wb.ack` not seen on any `s_ack`.
- **Reset mid-burst:** `sreset` pulsed during GRANT → all outputs at reset values the next cycle, pointer=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
//
// Purpose : shared types for the Wishbone round-robin arbiter.
//
// Contents:
//   state_t : arbiter FSM encoding.
//             IDLE  - no master owns the downstream bus.
//             GRANT - one master owns the bus for the whole of its cyc.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : wb_arbiter_pkg

// File: rtl/wishbone.sv
// -----------------------------------------------------------------------------
// wishbone
//
// Purpose : one pipelined Wishbone B4 bus (single master, single slave).
//
// Handshake: a strobe is transferred on a rising clock edge where
//   cyc && stb && !stall. The slave later answers every transferred strobe
//   with exactly one ack cycle, in order; dat_s2m is valid while ack is high.
//
// Parameters:
//   ADDR_BITS : address width
//   BYTES     : data width in bytes
//   SEL_WIDTH : byte-select width
//
// Modports:
//   master : drives addr/dat_m2s/we/sel/stb/cyc, receives dat_s2m/ack/stall
//   slave  : the mirror image
// -----------------------------------------------------------------------------
interface wishbone #(
  parameter int ADDR_BITS = 1,
  parameter int BYTES     = 1,
  parameter int SEL_WIDTH = 1
);

  logic [ADDR_BITS-1:0] addr;
  logic [BYTES*8-1:0]   dat_m2s;
  logic [BYTES*8-1:0]   dat_s2m;
  logic                 we;
  logic [SEL_WIDTH-1:0] sel;
  logic                 stb;
  logic                 cyc;
  logic                 ack;
  logic                 stall;

  modport master (
    output addr, dat_m2s, we, sel, stb, cyc,
    input  dat_s2m, ack, stall
  );

  modport slave (
    input  addr, dat_m2s, we, sel, stb, cyc,
    output dat_s2m, ack, stall
  );

endinterface : wishbone

// File: rtl/wb_arbiter_rr_select.sv
// -----------------------------------------------------------------------------
// rr_select
//
// Purpose : purely combinational round-robin pick. Returns the first
//           requester at or after ptr, wrapping past the top index back to 0.
//           Kept free of any arbiter state so other arbiters can reuse it.
//
// Parameters:
//   NUM_REQUESTERS : number of request lines (>= 2)
//
// Ports:
//   req   in  NUM_REQUESTERS  one request bit per requester
//   ptr   in  IDX_W           index with highest priority this cycle
//   valid out 1               at least one request is present
//   idx   out IDX_W           chosen requester (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_select #(
  parameter  int NUM_REQUESTERS = 2,
  localparam int IDX_W          = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]          ptr,
  output logic                      valid,
  output logic [IDX_W-1:0]          idx
);

  // Walk the offsets from farthest to nearest so the nearest requesting
  // candidate (smallest offset from ptr) is the last one written and wins.
  always_comb begin
    int cand;
    cand  = 0;
    valid = |req;
    idx   = '0;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQUESTERS) begin
        cand = cand - NUM_REQUESTERS;
      end
      if (req[IDX_W'(cand)]) begin
        idx = IDX_W'(cand);
      end
    end
  end

endmodule : rr_select

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Purpose : shares one pipelined Wishbone slave port between NUM_REQUESTERS
//           masters. Ownership is granted round-robin and held for the whole
//           of the owner's cyc. Accepted-but-unacked strobes are counted so
//           issue can be throttled at MAX_OUTSTANDING and acks routed back.
//
// Parameters:
//   NUM_REQUESTERS  : upstream masters (>= 2)
//   ADDR_BITS       : address width
//   BYTES           : data width in bytes
//   SEL_WIDTH       : byte-select width
//   MAX_OUTSTANDING : accepted-but-unacked strobe limit (>= 1)
//
// Ports (requester i occupies slice [(i+1)*W-1 -: W] of each flat bus):
//   clk        in   sole clock
//   sreset     in   synchronous active-high reset
//   s_addr     in   N*ADDR_BITS   per-requester address
//   s_dat_m2s  in   N*BYTES*8     per-requester write data
//   s_dat_s2m  out  N*BYTES*8     per-requester read data (0 unless granted)
//   s_we       in   N             per-requester write enable
//   s_sel      in   N*SEL_WIDTH   per-requester byte selects
//   s_stb      in   N             per-requester strobe
//   s_cyc      in   N             per-requester cycle
//   s_ack      out  N             per-requester ack (0 unless granted)
//   s_stall    out  N             per-requester stall (1 unless granted)
//   m_wb       wishbone.master    shared downstream bus
//   dbg_state  out  state_t       FSM state
//   dbg_grant  out  IDX_W         current grant index
//   dbg_ptr    out  IDX_W         round-robin pointer
//   dbg_outst  out  CNT_W         outstanding strobe count
//
// Handshake (both sides): a strobe moves on a clock edge where stb is high
// and stall is low; each moved strobe is answered by one ack cycle.
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int NUM_REQUESTERS  = 2,
  parameter  int ADDR_BITS       = 1,
  parameter  int BYTES           = 1,
  parameter  int SEL_WIDTH       = 1,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int IDX_W           = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int DW              = BYTES * 8
) (
  input  logic                                clk,
  input  logic                                sreset,
  input  logic [NUM_REQUESTERS*ADDR_BITS-1:0] s_addr,
  input  logic [NUM_REQUESTERS*DW-1:0]        s_dat_m2s,
  output logic [NUM_REQUESTERS*DW-1:0]        s_dat_s2m,
  input  logic [NUM_REQUESTERS-1:0]           s_we,
  input  logic [NUM_REQUESTERS*SEL_WIDTH-1:0] s_sel,
  input  logic [NUM_REQUESTERS-1:0]           s_stb,
  input  logic [NUM_REQUESTERS-1:0]           s_cyc,
  output logic [NUM_REQUESTERS-1:0]           s_ack,
  output logic [NUM_REQUESTERS-1:0]           s_stall,
  wishbone.master                             m_wb,
  output state_t                              dbg_state,
  output logic [IDX_W-1:0]                    dbg_grant,
  output logic [IDX_W-1:0]                    dbg_ptr,
  output logic [CNT_W-1:0]                    dbg_outst
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTERS - 1);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] outst_q;

  // ---------------------------------------------------------------------------
  // Flat buses unpacked into per-requester arrays so the granted slice can be
  // picked with a plain array index.
  // ---------------------------------------------------------------------------
  logic [ADDR_BITS-1:0] addr_a    [NUM_REQUESTERS];
  logic [DW-1:0]        dat_m2s_a [NUM_REQUESTERS];
  logic [SEL_WIDTH-1:0] sel_a     [NUM_REQUESTERS];
  logic [DW-1:0]        dat_s2m_a [NUM_REQUESTERS];

  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_slice
    assign addr_a[g]                  = s_addr[g*ADDR_BITS +: ADDR_BITS];
    assign dat_m2s_a[g]               = s_dat_m2s[g*DW +: DW];
    assign sel_a[g]                   = s_sel[g*SEL_WIDTH +: SEL_WIDTH];
    assign s_dat_s2m[g*DW +: DW]      = dat_s2m_a[g];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick among requesters currently holding cyc
  // ---------------------------------------------------------------------------
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_select #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_rr_select (
    .req   (s_cyc),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // ---------------------------------------------------------------------------
  // Outstanding-strobe bookkeeping
  // ---------------------------------------------------------------------------
  logic full;     // no more strobes may be issued until an ack arrives
  logic m_stb;    // strobe presented downstream
  logic accept;   // strobe moves downstream this cycle
  logic retire;   // ack that actually retires a counted strobe

  assign full   = (outst_q == MAX_CNT);
  assign accept = m_stb && !m_wb.stall;
  // An ack with nothing outstanding is a slave glitch; it must not wrap
  // the counter below zero.
  assign retire = m_wb.ack && (outst_q != '0);

  // ---------------------------------------------------------------------------
  // Datapath: zero-latency steering of the granted requester onto the bus.
  // Everything outside GRANT, and every non-granted requester, sees the
  // quiescent values (stall high, ack low, data zero).
  // ---------------------------------------------------------------------------
  always_comb begin
    m_stb          = 1'b0;
    m_wb.cyc       = 1'b0;
    m_wb.stb       = 1'b0;
    m_wb.addr      = '0;
    m_wb.dat_m2s   = '0;
    m_wb.we        = 1'b0;
    m_wb.sel       = '0;
    s_stall        = '1;
    s_ack          = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      dat_s2m_a[i] = '0;
    end

    if (state_q == GRANT) begin
      m_stb                = s_stb[grant_q] && !full;
      m_wb.cyc             = s_cyc[grant_q];
      m_wb.stb             = m_stb;
      m_wb.addr            = addr_a[grant_q];
      m_wb.dat_m2s         = dat_m2s_a[grant_q];
      m_wb.we              = s_we[grant_q];
      m_wb.sel             = sel_a[grant_q];
      // Throttle looks like a slave stall to the requester, so it simply
      // holds its strobe until the count drops.
      s_stall[grant_q]     = m_wb.stall || full;
      s_ack[grant_q]       = m_wb.ack;
      dat_s2m_a[grant_q]   = m_wb.dat_s2m;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, grant/pointer registers and outstanding counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      outst_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          outst_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_idx;
            state_q <= GRANT;
          end
        end

        GRANT: begin
          if (!s_cyc[grant_q]) begin
            // Owner finished or aborted. Strobes still in flight are
            // forgotten: their late acks land while no one is granted
            // and are dropped by the datapath.
            state_q <= IDLE;
            outst_q <= '0;
            ptr_q   <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          end else if (accept && !retire) begin
            outst_q <= outst_q + 1'b1;
          end else if (retire && !accept) begin
            outst_q <= outst_q - 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Debug visibility
  // ---------------------------------------------------------------------------
  assign dbg_state = state_q;
  assign dbg_grant = grant_q;
  assign dbg_ptr   = ptr_q;
  assign dbg_outst = outst_q;

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Bench for wb_arbiter with three requesters and an outstanding limit of 2.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int BY = 1;
  localparam int SW = 1;
  localparam int MO = 2;
  localparam int DW = BY * 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           sreset;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_dat_m2s;
  logic [N*DW-1:0] s_dat_s2m;
  logic [N-1:0]    s_we;
  logic [N*SW-1:0] s_sel;
  logic [N-1:0]    s_stb;
  logic [N-1:0]    s_cyc;
  logic [N-1:0]    s_ack;
  logic [N-1:0]    s_stall;
  state_t          dbg_state;
  logic [1:0]      dbg_grant;
  logic [1:0]      dbg_ptr;
  logic [1:0]      dbg_outst;

  always #5 clk = ~clk;

  wishbone #(.ADDR_BITS(AW), .BYTES(BY), .SEL_WIDTH(SW)) wb ();

  wb_arbiter #(
    .NUM_REQUESTERS  (N),
    .ADDR_BITS       (AW),
    .BYTES           (BY),
    .SEL_WIDTH       (SW),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk       (clk),
    .sreset    (sreset),
    .s_addr    (s_addr),
    .s_dat_m2s (s_dat_m2s),
    .s_dat_s2m (s_dat_s2m),
    .s_we      (s_we),
    .s_sel     (s_sel),
    .s_stb     (s_stb),
    .s_cyc     (s_cyc),
    .s_ack     (s_ack),
    .s_stall   (s_stall),
    .m_wb      (wb),
    .dbg_state (dbg_state),
    .dbg_grant (dbg_grant),
    .dbg_ptr   (dbg_ptr),
    .dbg_outst (dbg_outst)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int             checks = 0;
  int             errors = 0;
  logic [DW-1:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    s_addr     = '0;
    s_dat_m2s  = '0;
    s_we       = '0;
    s_sel      = '0;
    s_stb      = '0;
    s_cyc      = '0;
    wb.ack     = 1'b0;
    wb.stall   = 1'b0;
    wb.dat_s2m = '0;
  endtask

  task automatic do_reset();
    drive_quiet();
    sreset = 1'b1;
    step();
    step();
    sreset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table: requester 0 only. Fields:
  //   in = {s_cyc[0], s_stb[0], m stall, m ack}
  //   ex = {m cyc, m stb, s_stall[0], s_ack[0]}
  //   st/outst = state and outstanding count during that cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] in;
    state_t     st;
    logic [3:0] ex;
    logic [1:0] outst;
  } vec_t;

  vec_t tbl[20];

  // Watchdog: every loop below is bounded, this only guards against a stuck
  // simulator scheduler.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0]   a;
    int           acks;
    logic [N-1:0] acked_prev;
    logic [N-1:0] issued;
    logic         ack_pend;
    int           grants[$];
    state_t       prev_state;
    int           idle_run;
    int           own;
    int           ptr;
    int           outst;
    logic         e_mcyc;
    logic         e_mstb;
    logic [N-1:0] e_stall;
    logic [N-1:0] e_ack;
    logic [N*DW-1:0] e_dat;

    tbl[0]  = '{4'b1100, IDLE,  4'b0010, 2'd0};
    tbl[1]  = '{4'b1100, GRANT, 4'b1100, 2'd0};
    tbl[2]  = '{4'b1100, GRANT, 4'b1100, 2'd1};
    tbl[3]  = '{4'b1100, GRANT, 4'b1010, 2'd2};
    tbl[4]  = '{4'b1100, GRANT, 4'b1010, 2'd2};
    tbl[5]  = '{4'b1101, GRANT, 4'b1011, 2'd2};
    tbl[6]  = '{4'b1100, GRANT, 4'b1100, 2'd1};
    tbl[7]  = '{4'b1100, GRANT, 4'b1010, 2'd2};
    tbl[8]  = '{4'b1001, GRANT, 4'b1011, 2'd2};
    tbl[9]  = '{4'b1101, GRANT, 4'b1101, 2'd1};
    tbl[10] = '{4'b1000, GRANT, 4'b1000, 2'd1};
    tbl[11] = '{4'b1001, GRANT, 4'b1001, 2'd1};
    tbl[12] = '{4'b1001, GRANT, 4'b1001, 2'd0};
    tbl[13] = '{4'b1000, GRANT, 4'b1000, 2'd0};
    tbl[14] = '{4'b1110, GRANT, 4'b1110, 2'd0};
    tbl[15] = '{4'b1100, GRANT, 4'b1100, 2'd0};
    tbl[16] = '{4'b1100, GRANT, 4'b1100, 2'd1};
    tbl[17] = '{4'b0000, GRANT, 4'b0010, 2'd2};
    tbl[18] = '{4'b0001, IDLE,  4'b0010, 2'd0};
    tbl[19] = '{4'b0001, IDLE,  4'b0010, 2'd0};

    // ---- reset values (ack pushed from the slave must not leak) ----------
    do_reset();
    wb.ack     = 1'b1;
    wb.dat_s2m = 8'h5A;
    @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_grant", dbg_grant, 0);
    chk("rst_ptr",   dbg_ptr,   0);
    chk("rst_outst", dbg_outst, 0);
    chk("rst_mcyc",  wb.cyc,    0);
    chk("rst_mstb",  wb.stb,    0);
    chk("rst_stall", s_stall,   3'b111);
    chk("rst_ack",   s_ack,     3'b000);
    chk("rst_dat",   s_dat_s2m, 24'h0);
    step();
    wb.ack     = 1'b0;
    wb.dat_s2m = '0;

    // ---- single requester: 3 back-to-back reads on requester 1 -----------
    s_cyc[1]     = 1'b1;
    s_stb[1]     = 1'b1;
    s_addr[15:8] = 8'h10;
    @(negedge clk);
    chk("single_idle_mcyc",  wb.cyc,  0);
    chk("single_idle_stall", s_stall, 3'b111);
    step();
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      a            = 8'h10 + 8'(k);
      s_stb[1]     = (k < 3);
      s_addr[15:8] = a;
      wb.ack       = (k >= 1);
      wb.dat_s2m   = (a - 8'h01) ^ 8'hA5;
      @(negedge clk);
      chk("single_mcyc",   wb.cyc,     1);
      chk("single_mstb",   wb.stb,     (k < 3));
      chk("single_stall0", s_stall[0], 1);
      chk("single_stall2", s_stall[2], 1);
      if (k < 3) chk("single_addr", wb.addr, a);
      if (s_ack[1]) begin
        acks++;
        if (exp_q.size() == 0) chk("single_unexpected_ack", 1, 0);
        else chk("single_dat", s_dat_s2m[15:8], exp_q.pop_front());
        chk("single_dat_other", {s_dat_s2m[23:16], s_dat_s2m[7:0]}, 16'h0);
      end
      if (wb.stb && !wb.stall) exp_q.push_back(a ^ 8'hA5);
      step();
    end
    chk("single_ack_count", acks, 3);
    s_cyc[1] = 1'b0;
    s_stb[1] = 1'b0;
    wb.ack   = 1'b0;
    @(negedge clk);
    chk("single_release_mcyc", wb.cyc, 0);
    step();
    @(negedge clk);
    chk("single_release_state", dbg_state, IDLE);
    chk("single_release_ptr",   dbg_ptr,   2);
    step();

    // ---- round robin: requesters 0 and 2 keep coming back -----------------
    do_reset();
    acked_prev = '0;
    issued     = '0;
    ack_pend   = 1'b0;
    prev_state = IDLE;
    idle_run   = 0;
    for (int c = 0; c < 30; c++) begin
      for (int r = 0; r < N; r += 2) begin
        if (acked_prev[r]) begin
          s_cyc[r]  = 1'b0;
          issued[r] = 1'b0;
        end else begin
          s_cyc[r] = 1'b1;
        end
        s_stb[r] = s_cyc[r] && !issued[r];
      end
      wb.ack     = ack_pend;
      wb.dat_s2m = 8'h33;
      @(negedge clk);
      if (dbg_state == GRANT && prev_state == IDLE) begin
        if (grants.size() > 0) chk("rr_idle_gap", idle_run, 1);
        grants.push_back(int'(dbg_grant));
      end
      idle_run   = (dbg_state == IDLE) ? idle_run + 1 : 0;
      prev_state = dbg_state;
      acked_prev = s_ack;
      for (int r = 0; r < N; r++) begin
        if (s_stb[r] && !s_stall[r]) issued[r] = 1'b1;
      end
      ack_pend = wb.stb && !wb.stall;
      step();
    end
    chk("rr_grant_count", (grants.size() >= 4), 1);
    for (int i = 0; i < grants.size(); i++) begin
      chk($sformatf("rr_order%0d", i), grants[i], (i % 2 == 0) ? 0 : 2);
    end
    drive_quiet();

    // ---- table: throttle, simultaneous accept/ack, spurious ack, abort ----
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_cyc[0]    = tbl[i].in[3];
      s_stb[0]    = tbl[i].in[2];
      wb.stall    = tbl[i].in[1];
      wb.ack      = tbl[i].in[0];
      wb.dat_s2m  = 8'h40 + 8'(i);
      s_addr[7:0] = 8'(i);
      @(negedge clk);
      chk($sformatf("tbl%0d_state", i), dbg_state, tbl[i].st);
      chk($sformatf("tbl%0d_outst", i), dbg_outst, tbl[i].outst);
      chk($sformatf("tbl%0d_mcyc",  i), wb.cyc,    tbl[i].ex[3]);
      chk($sformatf("tbl%0d_mstb",  i), wb.stb,    tbl[i].ex[2]);
      chk($sformatf("tbl%0d_stall", i), s_stall,   {2'b11, tbl[i].ex[1]});
      chk($sformatf("tbl%0d_ack",   i), s_ack,     {2'b00, tbl[i].ex[0]});
      if (tbl[i].ex[0]) chk($sformatf("tbl%0d_dat", i), s_dat_s2m, {16'h0, 8'h40 + 8'(i)});
      step();
    end
    drive_quiet();

    // ---- reset in the middle of a burst on requester 2 --------------------
    s_cyc[2] = 1'b1;
    s_stb[2] = 1'b1;
    step();
    @(negedge clk);
    chk("rstmid_grant", dbg_grant, 2);
    step();
    sreset     = 1'b1;
    wb.ack     = 1'b1;
    wb.dat_s2m = 8'hC3;
    s_cyc[0]   = 1'b1;
    @(negedge clk);
    chk("rstmid_pre_mcyc", wb.cyc, 1);
    step();
    sreset = 1'b0;
    @(negedge clk);
    chk("rstmid_state", dbg_state, IDLE);
    chk("rstmid_grant0", dbg_grant, 0);
    chk("rstmid_ptr",   dbg_ptr,   0);
    chk("rstmid_outst", dbg_outst, 0);
    chk("rstmid_mcyc",  wb.cyc,    0);
    chk("rstmid_mstb",  wb.stb,    0);
    chk("rstmid_stall", s_stall,   3'b111);
    chk("rstmid_ack",   s_ack,     3'b000);
    chk("rstmid_dat",   s_dat_s2m, 24'h0);
    step();
    @(negedge clk);
    chk("rstmid_pick_after", dbg_grant, 0);
    step();

    // ---- randomized traffic against a reference model ---------------------
    do_reset();
    own   = -1;
    ptr   = 0;
    outst = 0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 7) == 0) s_cyc[r] = ~s_cyc[r];
        s_stb[r] = s_cyc[r] && ($urandom_range(0, 1) == 1);
      end
      s_we       = 3'($urandom);
      s_sel      = 3'($urandom);
      s_addr     = 24'($urandom);
      s_dat_m2s  = 24'($urandom);
      wb.stall   = ($urandom_range(0, 3) == 0);
      wb.ack     = (outst > 0) && ($urandom_range(0, 1) == 1);
      wb.dat_s2m = 8'($urandom);

      e_mcyc  = 1'b0;
      e_mstb  = 1'b0;
      e_stall = '1;
      e_ack   = '0;
      e_dat   = '0;
      if (own >= 0) begin
        e_mcyc              = s_cyc[own];
        e_mstb              = s_stb[own] && (outst < MO);
        e_stall[own]        = wb.stall || (outst == MO);
        e_ack[own]          = wb.ack;
        e_dat[own*DW +: DW] = wb.dat_s2m;
      end

      @(negedge clk);
      chk("rnd_granted", (dbg_state == GRANT), (own >= 0));
      chk("rnd_outst",   dbg_outst, outst);
      chk("rnd_mcyc",    wb.cyc,    e_mcyc);
      chk("rnd_mstb",    wb.stb,    e_mstb);
      chk("rnd_stall",   s_stall,   e_stall);
      chk("rnd_ack",     s_ack,     e_ack);
      chk("rnd_dat",     s_dat_s2m, e_dat);
      if (own >= 0) begin
        chk("rnd_addr", wb.addr,    s_addr[own*AW +: AW]);
        chk("rnd_wdat", wb.dat_m2s, s_dat_m2s[own*DW +: DW]);
        chk("rnd_we",   wb.we,      s_we[own]);
        chk("rnd_sel",  wb.sel,     s_sel[own*SW +: SW]);
      end

      if (own < 0) begin
        for (int k = 0; k < N; k++) begin
          if (own < 0 && s_cyc[(ptr + k) % N]) own = (ptr + k) % N;
        end
      end else if (!s_cyc[own]) begin
        ptr   = (own + 1) % N;
        own   = -1;
        outst = 0;
      end else begin
        outst = outst + ((e_mstb && !wb.stall) ? 1 : 0) - (wb.ack ? 1 : 0);
      end
      step();
    end
    drive_quiet();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_arbiter
